// File: rtl/dct_pingpong_ctrl.sv
// dct_pingpong_ctrl: ping-pong transpose-bank sequencer between the row and column DCT stages.
// Rows fill one bank while the other drains column by column.
module dct_pingpong_ctrl #(
   parameter int N     = 8,
   parameter int CNT_W = 15
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic                 wr_en,
   output logic                 wr_bank,
   output logic [$clog2(N)-1:0] wr_row,
   output logic                 rd_en,
   output logic                 rd_bank,
   output logic [$clog2(N)-1:0] rd_col,
   input  logic                 out_ready,
   output logic                 out_valid,
   output logic                 dc_sel,
   output logic                 out_last,
   output logic [CNT_W-1:0]     blk_in_cnt,
   output logic [CNT_W-1:0]     blk_out_cnt,
   output logic                 busy
);
   localparam int AW = $clog2(N);
   localparam logic [AW-1:0] LAST = AW'(N - 1);
   logic [1:0] full;
   logic [1:0] full_nxt;
   logic       wr_done;
   logic       rd_done;
   assign in_ready = !full[wr_bank];
   assign wr_en    = in_valid & in_ready;
   assign rd_en    = full[rd_bank] & (!out_valid | out_ready);
   assign wr_done  = wr_en & (wr_row == LAST);
   assign rd_done  = rd_en & (rd_col == LAST);
   assign busy     = (|full) | (wr_row != '0) | out_valid;
   // a fill and a drain completing together always touch opposite banks
   always_comb begin
      full_nxt = full;
      if (wr_done) full_nxt[wr_bank] = 1'b1;
      if (rd_done) full_nxt[rd_bank] = 1'b0;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         full        <= '0;
         wr_bank     <= 1'b0;
         rd_bank     <= 1'b0;
         wr_row      <= '0;
         rd_col      <= '0;
         out_valid   <= 1'b0;
         dc_sel      <= 1'b0;
         out_last    <= 1'b0;
         blk_in_cnt  <= '0;
         blk_out_cnt <= '0;
      end else begin
         full <= full_nxt;
         if (wr_en) wr_row <= wr_row + 1'b1;
         if (wr_done) begin
            wr_bank    <= !wr_bank;
            blk_in_cnt <= blk_in_cnt + 1'b1;
         end
         if (rd_en) rd_col <= rd_col + 1'b1;
         if (rd_done) begin
            rd_bank     <= !rd_bank;
            blk_out_cnt <= blk_out_cnt + 1'b1;
         end
         // column tags follow the read by one cycle to match the buffer read latency
         if (rd_en) begin
            out_valid <= 1'b1;
            dc_sel    <= (rd_col == '0);
            out_last  <= (rd_col == LAST);
         end else if (out_ready) begin
            out_valid <= 1'b0;
            dc_sel    <= 1'b0;
            out_last  <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_dct_pingpong_ctrl.sv
// tb_dct_pingpong_ctrl: directed scenarios plus randomized traffic checked every cycle
// against a row/column counting model of the ping-pong controller.
module tb_dct_pingpong_ctrl;
   localparam int N  = 8;
   localparam int CW = 3;
   localparam int AW = $clog2(N);
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic in_valid = 1'b0;
   logic out_ready = 1'b0;
   logic in_ready, wr_en, wr_bank, rd_en, rd_bank, out_valid, dc_sel, out_last, busy;
   logic [AW-1:0] wr_row, rd_col;
   logic [CW-1:0] blk_in_cnt, blk_out_cnt;
   int tests = 0;
   int fails = 0;
   int rows_in = 0;
   int cols_rd = 0;
   int m_col = 0;
   logic m_ov = 1'b0;

   dct_pingpong_ctrl #(.N(N), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .wr_en(wr_en), .wr_bank(wr_bank), .wr_row(wr_row),
      .rd_en(rd_en), .rd_bank(rd_bank), .rd_col(rd_col),
      .out_ready(out_ready), .out_valid(out_valid), .dc_sel(dc_sel), .out_last(out_last),
      .blk_in_cnt(blk_in_cnt), .blk_out_cnt(blk_out_cnt), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: everything follows from total rows accepted and total columns read since reset.
   always @(negedge clk) begin
      int bi, bo, d, e_rd;
      if (!reset) begin
         rows_in = 0;
         cols_rd = 0;
         m_ov    = 1'b0;
         m_col   = 0;
      end
      bi   = rows_in / N;
      bo   = cols_rd / N;
      d    = bi - bo;
      e_rd = (d >= 1 && (!m_ov || out_ready)) ? 1 : 0;
      chk("in_ready", in_ready, d < 2);
      chk("wr_en", wr_en, in_valid && d < 2);
      chk("wr_bank", wr_bank, bi % 2);
      chk("wr_row", wr_row, rows_in % N);
      chk("rd_en", rd_en, e_rd);
      chk("rd_bank", rd_bank, bo % 2);
      chk("rd_col", rd_col, cols_rd % N);
      chk("out_valid", out_valid, m_ov);
      chk("dc_sel", dc_sel, m_ov && m_col == 0);
      chk("out_last", out_last, m_ov && m_col == N - 1);
      chk("blk_in_cnt", blk_in_cnt, bi % (1 << CW));
      chk("blk_out_cnt", blk_out_cnt, bo % (1 << CW));
      chk("busy", busy, d > 0 || rows_in % N != 0 || m_ov);
      if (reset) begin
         if (in_valid && d < 2) rows_in++;
         if (e_rd != 0) begin
            m_ov  = 1'b1;
            m_col = cols_rd % N;
            cols_rd++;
         end else if (out_ready) m_ov = 1'b0;
      end
   end

   task automatic cyc(input logic iv, input logic ordy);
      @(posedge clk);
      #1;
      in_valid  = iv;
      out_ready = ordy;
   endtask

   task automatic do_reset;
      @(posedge clk);
      #1;
      reset     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   task automatic single_block;
      int nov = 0;
      do_reset;
      for (int i = 0; i < N; i++) cyc(1'b1, 1'b1);
      for (int k = N; k <= 2 * N + 1; k++) begin
         cyc(1'b0, 1'b1);
         @(negedge clk);
         nov += out_valid;
         if (k == N) chk("s1_first_rd_en", rd_en, 1);
         if (k == N) chk("s1_no_early_valid", out_valid, 0);
         if (k == N + 1) chk("s1_dc_sel_col0", dc_sel, 1);
         if (k == 2 * N) chk("s1_out_last_col7", out_last, 1);
         if (k == 2 * N + 1) begin
            chk("s1_busy_idle", busy, 0);
            chk("s1_blk_in", blk_in_cnt, 1);
            chk("s1_blk_out", blk_out_cnt, 1);
         end
      end
      chk("s1_ov_cycles", nov, N);
   endtask

   initial begin
      int nov, nlow, nacc, ndc, pi, po;
      #2 reset = 1'b0;
      single_block;

      do_reset;
      nov  = 0;
      nlow = 0;
      for (int k = 0; k < 9 * N + 2; k++) begin
         cyc(k < 8 * N, 1'b1);
         @(negedge clk);
         nov  += out_valid;
         nlow += !in_ready;
         if (k == N + 1 || k == 9 * N) chk("s2_ov_edges", out_valid, 1);
      end
      chk("s2_ov_cycles", nov, 8 * N);
      chk("s2_in_ready_low", nlow, 0);
      chk("s2_blk_in_mod8", blk_in_cnt, 0);

      do_reset;
      nacc = 0;
      nlow = 0;
      for (int k = 0; k < 3 * N; k++) begin
         cyc(1'b1, 1'b0);
         @(negedge clk);
         nacc += wr_en;
         nlow += !in_ready;
      end
      chk("s3_accepted", nacc, 2 * N);
      chk("s3_ready_low", nlow, N);
      chk("s3_hold_valid", out_valid, 1);
      chk("s3_hold_dc", dc_sel, 1);
      nov = 0;
      ndc = 0;
      for (int k = 0; k < 5 * N; k++) begin
         cyc(1'b0, 1'b1);
         @(negedge clk);
         nov += out_valid;
         ndc += dc_sel;
      end
      chk("s3_cols_out", nov, 2 * N);
      chk("s3_dc_count", ndc, 2);

      do_reset;
      for (int i = 0; i < N; i++) cyc(1'b1, 1'b1);
      nov = 0;
      for (int k = N; k <= 2 * N + 4; k++) begin
         cyc(1'b0, !(k >= 12 && k <= 14));
         @(negedge clk);
         nov += out_valid;
         if (k >= 12 && k <= 15) chk("s4_hold_rd_col", rd_col, 4);
         if (k == 2 * N + 3) chk("s4_out_last", out_last, 1);
      end
      chk("s4_ov_cycles", nov, N + 3);

      do_reset;
      for (int k = 0; k < N + 5; k++) cyc(1'b1, 1'b1);
      @(posedge clk);
      #1;
      reset    = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("s5_ov_cleared", out_valid, 0);
      chk("s5_busy_cleared", busy, 0);
      chk("s5_wr_row_cleared", wr_row, 0);
      chk("s5_blk_in_cleared", blk_in_cnt, 0);
      single_block;

      do_reset;
      for (int k = 0; k < 10 * N + 2; k++) cyc(k < 9 * N, 1'b1);
      @(negedge clk);
      chk("s6_blk_in_wrap", blk_in_cnt, 1);
      chk("s6_blk_out_wrap", blk_out_cnt, 1);

      do_reset;
      for (int p = 0; p < 8; p++) begin
         pi = $urandom_range(1, 9);
         po = $urandom_range(1, 9);
         for (int k = 0; k < 500; k++) begin
            if ($urandom_range(0, 999) == 0) do_reset;
            cyc($urandom_range(0, 9) < pi, $urandom_range(0, 9) < po);
         end
      end
      repeat (4 * N) cyc(1'b0, 1'b1);
      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
